// File: rtl/serial_parity_tx_pkg.sv
// serial_pkg: shared types and default constants for the serial_parity_tx slice.
//   tx_state_t      : frame sequencer states
//   NDATA_DEF       : default data bits per frame
//   BIT_CYCLES_DEF  : default clk_2 cycles per serial bit
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int NDATA_DEF      = 8;
    localparam int BIT_CYCLES_DEF = 1;

endpackage

// File: rtl/serial_parity_tx_if.sv
// serial_parity_tx_if: request/serial-output bundle of the frame transmitter.
//   start      : frame request (master -> slave)
//   data       : word to send (master -> slave)
//   tx_bit     : serial line, idles high (slave -> master)
//   busy       : frame in flight (slave -> master)
//   done       : one-cycle end-of-frame pulse (slave -> master)
//   parity_out : parity bit of last completed frame (slave -> master)
interface serial_parity_tx_if #(
    parameter int NDATA = serial_pkg::NDATA_DEF
);
    logic             start;
    logic [NDATA-1:0] data;
    logic             tx_bit;
    logic             busy;
    logic             done;
    logic             parity_out;

    modport master (
        output start, data,
        input  tx_bit, busy, done, parity_out
    );

    modport slave (
        input  start, data,
        output tx_bit, busy, done, parity_out
    );
endinterface

// File: rtl/serial_parity_tx_parity_acc.sv
// parity_acc: two-state (PAR/IMPAR) running parity accumulator.
//   clk_2   : clock
//   reset   : synchronous active-high reset
//   clear   : return to the initial state (wins over en)
//   en      : fold in_bit into the running parity
//   in_bit  : bit to accumulate
//   out_bit : current parity bit (1 in IMPAR)
// Build option PARITY_ODD_EN: initial state is IMPAR, so out_bit is the
// odd-parity bit instead of the even-parity bit.
module parity_acc (
    input  logic clk_2,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic in_bit,
    output logic out_bit
);
    typedef enum logic {PAR = 1'b0, IMPAR = 1'b1} acc_state_t;

`ifdef PARITY_ODD_EN
    localparam acc_state_t INIT_STATE = IMPAR;
`else
    localparam acc_state_t INIT_STATE = PAR;
`endif

    acc_state_t state, state_n;

    always_ff @(posedge clk_2) begin
        if (reset) state <= INIT_STATE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (clear) begin
            state_n = INIT_STATE;
        end else if (en && in_bit) begin
            state_n = (state == PAR) ? IMPAR : PAR;
        end
    end

    assign out_bit = (state == IMPAR);
endmodule

// File: rtl/serial_parity_tx.sv
// serial_parity_tx: sends one word as start bit, data LSB first, parity bit,
// stop bit; every bit held BIT_CYCLES clk_2 cycles.
//   clk_2 : clock
//   reset : synchronous active-high reset, aborts any frame in flight
//   bus   : serial_parity_tx_if.slave (start, data in; tx_bit, busy, done,
//           parity_out out; all outputs registered)
// Parity sense (even, or odd with PARITY_ODD_EN) lives inside parity_acc.
//
// state  | meaning
// IDLE   | line high, waiting for start
// START  | start bit (low)
// DATA   | shifting data bits out, LSB first
// PARITY | accumulated parity bit
// STOP   | stop bit (high)
module serial_parity_tx
    import serial_pkg::*;
#(
    parameter int NDATA      = NDATA_DEF,
    parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
    input  logic              clk_2,
    input  logic              reset,
    serial_parity_tx_if.slave bus
);
    localparam int BW = $clog2(NDATA + 1);

    tx_state_t        state, state_n;
    logic [7:0]       cyc_cnt, cyc_cnt_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [NDATA-1:0] shift_q, shift_n;
    logic             tx_q, tx_n;
    logic             busy_q, done_q, done_n;
    logic             par_q, par_n;
    logic             acc_clear, acc_en, acc_out;
    logic             par_rst;
    logic             last_cyc, last_bit;

    parity_acc u_acc (
        .clk_2   (clk_2),
        .reset   (reset),
        .clear   (acc_clear),
        .en      (acc_en),
        .in_bit  (tx_q),
        .out_bit (acc_out)
    );

    // Permanently cleared copy: its output is the parity of an empty word,
    // which is the reset value parity_out must take for the built parity sense.
    parity_acc u_par_ref (
        .clk_2   (clk_2),
        .reset   (reset),
        .clear   (1'b1),
        .en      (1'b0),
        .in_bit  (1'b0),
        .out_bit (par_rst)
    );

    assign last_cyc = (cyc_cnt == 8'(BIT_CYCLES - 1));
    assign last_bit = (bit_cnt == BW'(NDATA - 1));

    always_comb begin
        state_n   = state;
        cyc_cnt_n = cyc_cnt;
        bit_cnt_n = bit_cnt;
        shift_n   = shift_q;
        acc_clear = 1'b0;
        acc_en    = 1'b0;
        done_n    = 1'b0;
        par_n     = par_q;
        tx_n      = 1'b1;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    shift_n   = bus.data;
                    acc_clear = 1'b1;
                    bit_cnt_n = '0;
                    cyc_cnt_n = '0;
                    state_n   = START;
                end
            end
            START, PARITY, STOP: begin
                if (last_cyc) begin
                    cyc_cnt_n = '0;
                    case (state)
                        START:   state_n = DATA;
                        PARITY:  state_n = STOP;
                        default: begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                            par_n   = acc_out;
                        end
                    endcase
                end else begin
                    cyc_cnt_n = cyc_cnt + 8'd1;
                end
            end
            DATA: begin
                if (last_cyc) begin
                    acc_en    = 1'b1;
                    shift_n   = shift_q >> 1;
                    bit_cnt_n = bit_cnt + BW'(1);
                    cyc_cnt_n = '0;
                    if (last_bit) state_n = PARITY;
                end else begin
                    cyc_cnt_n = cyc_cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // tx_bit is registered, so it is computed for the state being entered.
        // On the DATA->PARITY edge the accumulator is still absorbing the last
        // data bit, so its next value is formed here directly.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = (state == DATA) ? (acc_out ^ tx_q) : acc_out;
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            par_q   <= par_rst;
        end else begin
            state   <= state_n;
            cyc_cnt <= cyc_cnt_n;
            bit_cnt <= bit_cnt_n;
            shift_q <= shift_n;
            tx_q    <= tx_n;
            busy_q  <= (state_n != IDLE);
            done_q  <= done_n;
            par_q   <= par_n;
        end
    end

    assign bus.tx_bit     = tx_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.parity_out = par_q;
endmodule

// File: tb/tb_serial_parity_tx.sv
module tb_serial_parity_tx;
    import serial_pkg::*;

`ifdef PARITY_ODD_EN
    localparam bit ODD = 1'b1;
`else
    localparam bit ODD = 1'b0;
`endif

    logic clk_2 = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   exp_q[$];

    always #5 clk_2 = ~clk_2;

    serial_parity_tx_if #(.NDATA(8)) bus_a ();
    serial_parity_tx_if #(.NDATA(8)) bus_b ();

    serial_parity_tx #(.NDATA(8), .BIT_CYCLES(1)) dut_a (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus_a)
    );

    serial_parity_tx #(.NDATA(8), .BIT_CYCLES(3)) dut_b (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus_b)
    );

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic get(input bit sel, output logic tx, output logic bsy,
                       output logic dn, output logic par);
        tx  = sel ? bus_b.tx_bit     : bus_a.tx_bit;
        bsy = sel ? bus_b.busy       : bus_a.busy;
        dn  = sel ? bus_b.done       : bus_a.done;
        par = sel ? bus_b.parity_out : bus_a.parity_out;
    endtask

    task automatic set_req(input bit sel, input logic s, input logic [7:0] d);
        if (sel) begin
            bus_b.start = s;
            bus_b.data  = d;
        end else begin
            bus_a.start = s;
            bus_a.data  = d;
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input int bc);
        for (int c = 0; c < bc; c++) exp_q.push_back(1'b0);
        for (int k = 0; k < 8; k++)
            for (int c = 0; c < bc; c++) exp_q.push_back(d[k]);
        for (int c = 0; c < bc; c++) exp_q.push_back((^d) ^ ODD);
        for (int c = 0; c < bc; c++) exp_q.push_back(1'b1);
    endtask

    // Called just after a negedge; start is sampled on the following posedge.
    task automatic send(input bit sel, input logic [7:0] d);
        push_frame(d, sel ? 3 : 1);
        set_req(sel, 1'b1, d);
        @(posedge clk_2);
        #1;
        set_req(sel, 1'b0, d);
    endtask

    task automatic pop_chk(input bit sel, input string tag, input int i);
        logic tx, bsy, dn, par;
        bit   e;
        get(sel, tx, bsy, dn, par);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_q observed=empty expected=entry at cycle %0d", tag, i);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("%s_tx[%0d]", tag, i), tx, e);
        end
        chk($sformatf("%s_busy[%0d]", tag, i), bsy, 1'b1);
        chk($sformatf("%s_done[%0d]", tag, i), dn, 1'b0);
    endtask

    // Walks one frame cycle by cycle; optionally pulses start with 8'hFF at
    // frame cycle index mid. Returns at the negedge of the done cycle.
    task automatic check_frame(input bit sel, input string tag,
                               input logic [7:0] d, input int mid);
        logic tx, bsy, dn, par;
        int   len;
        len = exp_q.size();
        for (int i = 0; i < len; i++) begin
            @(negedge clk_2);
            pop_chk(sel, tag, i);
            if (i == mid) set_req(sel, 1'b1, 8'hFF);
            else if (sel) bus_b.start = 1'b0;
            else           bus_a.start = 1'b0;
        end
        @(negedge clk_2);
        get(sel, tx, bsy, dn, par);
        chk({tag, "_done"}, dn, 1'b1);
        chk({tag, "_busy_end"}, bsy, 1'b0);
        chk({tag, "_tx_end"}, tx, 1'b1);
        chk({tag, "_parity_out"}, par, (^d) ^ ODD);
    endtask

    initial begin
        logic tx, bsy, dn, par;
        reset = 1'b1;
        set_req(1'b0, 1'b0, 8'h00);
        set_req(1'b1, 1'b0, 8'h00);
        repeat (3) @(posedge clk_2);
        #1;
        reset = 1'b0;

        @(negedge clk_2);
        for (int s = 0; s < 2; s++) begin
            get(s[0], tx, bsy, dn, par);
            chk($sformatf("rst_tx%0d", s), tx, 1'b1);
            chk($sformatf("rst_busy%0d", s), bsy, 1'b0);
            chk($sformatf("rst_done%0d", s), dn, 1'b0);
            chk($sformatf("rst_par%0d", s), par, ODD);
        end

        @(negedge clk_2);
        send(1'b0, 8'hA5);
        check_frame(1'b0, "a5", 8'hA5, -1);

        @(negedge clk_2);
        send(1'b0, 8'h07);
        check_frame(1'b0, "07", 8'h07, -1);

        // Mid-frame request with new data is ignored; start during done chains.
        @(negedge clk_2);
        send(1'b0, 8'h3C);
        check_frame(1'b0, "3c", 8'h3C, 3);
        send(1'b0, 8'h01);
        check_frame(1'b0, "b2b01", 8'h01, -1);

        @(negedge clk_2);
        send(1'b0, 8'hA5);
        check_frame(1'b0, "a5b", 8'hA5, -1);

        // Reset while data bit 4 is on the line (frame cycle 6).
        @(negedge clk_2);
        send(1'b0, 8'h5A);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_2);
            pop_chk(1'b0, "abort", i);
        end
        reset = 1'b1;
        @(negedge clk_2);
        get(1'b0, tx, bsy, dn, par);
        chk("abort_tx", tx, 1'b1);
        chk("abort_busy", bsy, 1'b0);
        chk("abort_done", dn, 1'b0);
        chk("abort_par", par, ODD);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk_2);
        get(1'b0, tx, bsy, dn, par);
        chk("post_abort_tx", tx, 1'b1);
        chk("post_abort_done", dn, 1'b0);

        send(1'b0, 8'h07);
        check_frame(1'b0, "after_abort", 8'h07, -1);

        @(negedge clk_2);
        send(1'b1, 8'h80);
        check_frame(1'b1, "bc3_80", 8'h80, -1);

        @(negedge clk_2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
